// File: rtl/req_value_arbiter_if.sv
// Request/value bus shared by req_value_arbiter and its environment.
// slave = arbiter view, master = requester/consumer view.
interface req_value_arbiter_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = 2,
   parameter int unsigned DW   = 32
);
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_value;
   logic [NREQ-1:0]    req_ack;
   logic               out_valid;
   logic               out_ready;
   logic [DW-1:0]      out_value;
   logic [NREQ-1:0]    grant;
   logic [IW-1:0]      grant_idx;

   modport master (
      output req, req_value, out_ready,
      input  req_ack, out_valid, out_value, grant, grant_idx
   );

   modport slave (
      input  req, req_value, out_ready,
      output req_ack, out_valid, out_value, grant, grant_idx
   );
endinterface

// File: rtl/req_value_arbiter.sv
// Grants one of NREQ requesters, captures its value and presents it under valid/ready.
// Define REQ_ARB_ROUND_ROBIN_EN for rotating priority; default build is fixed lowest-index priority.
module req_value_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = 2,
   parameter int unsigned DW   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   req_value_arbiter_if.slave   bus
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [DW-1:0]     out_value_q, out_value_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [IW-1:0]     grant_idx_q, grant_idx_d;
   logic [NREQ-1:0]   req_ack_q, req_ack_d;
   logic [IW-1:0]     ptr;

`ifdef REQ_ARB_ROUND_ROBIN_EN
   logic [IW-1:0]     ptr_q, ptr_d;
   assign ptr = ptr_q;
`else
   assign ptr = '0;
`endif

   logic [DW-1:0]     req_vals [NREQ];
   logic [IW-1:0]     sel_idx;
   logic [IW-1:0]     cand;
   logic              found;

   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         req_vals[i] = bus.req_value[i*DW +: DW];
      end
   end

   // Scan upward from ptr; NREQ is a power of two so the IW-bit add wraps modulo NREQ.
   always_comb begin
      sel_idx = ptr;
      cand    = '0;
      found   = 1'b0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         cand = ptr + IW'(off);
         if (!found && bus.req[cand]) begin
            sel_idx = cand;
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_value_d = out_value_q;
      grant_d     = grant_q;
      grant_idx_d = grant_idx_q;
      req_ack_d   = '0;
`ifdef REQ_ARB_ROUND_ROBIN_EN
      ptr_d       = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               grant_d     = NREQ'(1) << sel_idx;
               grant_idx_d = sel_idx;
               out_value_d = req_vals[sel_idx];
               out_valid_d = 1'b1;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
               grant_d     = '0;
               req_ack_d   = grant_q;
`ifdef REQ_ARB_ROUND_ROBIN_EN
               ptr_d       = grant_idx_q + IW'(1);
`endif
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_value_q <= '0;
         grant_q     <= '0;
         grant_idx_q <= '0;
         req_ack_q   <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_value_q <= out_value_d;
         grant_q     <= grant_d;
         grant_idx_q <= grant_idx_d;
         req_ack_q   <= req_ack_d;
      end
   end

`ifdef REQ_ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   assign bus.out_valid = out_valid_q;
   assign bus.out_value = out_value_q;
   assign bus.grant     = grant_q;
   assign bus.grant_idx = grant_idx_q;
   assign bus.req_ack   = req_ack_q;

   a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(grant_q));
   a_ack_excl_valid : assert property (@(posedge clk) disable iff (!rst) !((|req_ack_q) && out_valid_q));

endmodule
